// File: rtl/h2c_line_unpacker_if.sv
// Stream bundle between the XDMA H2C channel and the line pipeline.
// The slave modport is the unpacker side (it sinks H2C, sources lines); master is the opposite end.
interface h2c_line_unpacker_if;
  logic [63:0] s_axis_h2c_tdata;
  logic [7:0]  s_axis_h2c_tkeep;
  logic        s_axis_h2c_tlast;
  logic        s_axis_h2c_tvalid;
  logic        s_axis_h2c_tready;
  logic [63:0] m_axis_line_tdata;
  logic [7:0]  m_axis_line_tkeep;
  logic        m_axis_line_tlast;
  logic        m_axis_line_tuser;
  logic [15:0] m_axis_line_id;
  logic        m_axis_line_tvalid;
  logic        m_axis_line_tready;

  modport slave (
    input  s_axis_h2c_tdata, s_axis_h2c_tkeep, s_axis_h2c_tlast, s_axis_h2c_tvalid,
    output s_axis_h2c_tready,
    output m_axis_line_tdata, m_axis_line_tkeep, m_axis_line_tlast, m_axis_line_tuser,
    output m_axis_line_id, m_axis_line_tvalid,
    input  m_axis_line_tready
  );

  modport master (
    output s_axis_h2c_tdata, s_axis_h2c_tkeep, s_axis_h2c_tlast, s_axis_h2c_tvalid,
    input  s_axis_h2c_tready,
    input  m_axis_line_tdata, m_axis_line_tkeep, m_axis_line_tlast, m_axis_line_tuser,
    input  m_axis_line_id, m_axis_line_tvalid,
    output m_axis_line_tready
  );
endinterface

// File: rtl/h2c_line_unpacker.sv
// Parses the one-beat line header of each H2C packet and forwards payload through a 2-entry skid buffer.
// Optional build macro H2C_TKEEP_CHECK_EN adds tkeep shape checking on payload beats.
module h2c_line_unpacker #(
  parameter int          C_DATA_WIDTH = 64,
  parameter int          MAX_BEATS    = 4096,
  parameter logic [15:0] HDR_MAGIC    = 16'hA55A
) (
  input  logic               user_clk,
  input  logic               user_rst,
  h2c_line_unpacker_if.slave bus,
  output logic [31:0]        line_count,
  output logic [15:0]        err_count,
  output logic               err_pulse
);

  typedef enum logic [1:0] {ST_HDR, ST_PAYLOAD, ST_DROP} state_t;

  typedef struct packed {
    logic [C_DATA_WIDTH-1:0] data;
    logic [7:0]              keep;
    logic                    last;
    logic                    user;
    logic [15:0]             id;
  } beat_t;

  state_t      state_q, state_d;
  logic [15:0] line_id_q, line_id_d;
  logic [12:0] len_m1_q, len_m1_d;
  logic [12:0] beat_cnt_q, beat_cnt_d;
  beat_t       out_q, out_d, skid_q, skid_d, fwd_beat;
  logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [31:0] line_count_q, line_count_d;
  logic [15:0] err_count_q, err_count_d;
  logic        err_pulse_q, err_pulse_d;

  logic        s_ready, fwd_valid, err_event, line_done, at_last, pop, line_keep_err;
  logic [15:0] hdr_magic, hdr_id, hdr_len;
  logic        hdr_len_ok;

  assign hdr_magic  = bus.s_axis_h2c_tdata[15:0];
  assign hdr_id     = bus.s_axis_h2c_tdata[31:16];
  assign hdr_len    = bus.s_axis_h2c_tdata[47:32];
  assign hdr_len_ok = (hdr_len != 16'd0) && (int'(hdr_len) <= MAX_BEATS);
  assign at_last    = (beat_cnt_q == len_m1_q);
  assign pop        = out_valid_q && bus.m_axis_line_tready;

`ifdef H2C_TKEEP_CHECK_EN
  logic       keep_err_q, keep_err_d, keep_beat_bad;
  logic [7:0] keep_plus1;

  assign keep_plus1 = bus.s_axis_h2c_tkeep + 8'd1;

  // A line-ending beat needs keep of the form 0..01..1; every other beat must be full.
  always_comb begin
    keep_beat_bad = (bus.s_axis_h2c_tkeep != 8'hFF);
    if (bus.s_axis_h2c_tlast || at_last) begin
      keep_beat_bad = (bus.s_axis_h2c_tkeep == 8'd0) ||
                      ((bus.s_axis_h2c_tkeep & keep_plus1) != 8'd0);
    end
  end

  assign line_keep_err = keep_err_q || keep_beat_bad;

  always_comb begin
    keep_err_d = keep_err_q;
    if (state_q == ST_HDR) begin
      keep_err_d = 1'b0;
    end else if (fwd_valid) begin
      keep_err_d = line_keep_err;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) keep_err_q <= 1'b0;
    else          keep_err_q <= keep_err_d;
  end
`else
  assign line_keep_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    line_id_d  = line_id_q;
    len_m1_d   = len_m1_q;
    beat_cnt_d = beat_cnt_q;
    s_ready    = 1'b0;
    fwd_valid  = 1'b0;
    fwd_beat   = '0;
    err_event  = 1'b0;
    line_done  = 1'b0;
    unique case (state_q)
      ST_HDR: begin
        s_ready = 1'b1;
        if (bus.s_axis_h2c_tvalid) begin
          line_id_d  = hdr_id;
          len_m1_d   = 13'(hdr_len - 16'd1);
          beat_cnt_d = '0;
          if (bus.s_axis_h2c_tlast) begin
            err_event = 1'b1;
          end else if (hdr_magic == HDR_MAGIC && hdr_len_ok) begin
            state_d = ST_PAYLOAD;
          end else begin
            err_event = 1'b1;
            state_d   = ST_DROP;
          end
        end
      end
      ST_PAYLOAD: begin
        s_ready       = !skid_valid_q;
        fwd_beat.data = bus.s_axis_h2c_tdata;
        fwd_beat.keep = bus.s_axis_h2c_tkeep;
        fwd_beat.id   = line_id_q;
        fwd_beat.last = bus.s_axis_h2c_tlast || at_last;
        // Short or long lines are cut at the first of tlast / expected length and flagged.
        fwd_beat.user = fwd_beat.last &&
                        (!(bus.s_axis_h2c_tlast && at_last) || line_keep_err);
        if (s_ready && bus.s_axis_h2c_tvalid) begin
          fwd_valid  = 1'b1;
          beat_cnt_d = beat_cnt_q + 13'd1;
          if (fwd_beat.last) begin
            if (fwd_beat.user) err_event = 1'b1;
            else               line_done = 1'b1;
            state_d = bus.s_axis_h2c_tlast ? ST_HDR : ST_DROP;
          end
        end
      end
      ST_DROP: begin
        s_ready = 1'b1;
        if (bus.s_axis_h2c_tvalid && bus.s_axis_h2c_tlast) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase

    line_count_d = line_count_q + {31'd0, line_done};
    err_count_d  = err_count_q;
    if (err_event && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
    err_pulse_d  = err_event;
  end

  // Skid buffer: the skid entry only fills when the output register is stalled.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (fwd_valid) begin
      if (!out_valid_q || pop) begin
        out_d       = fwd_beat;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = fwd_beat;
        skid_valid_d = 1'b1;
      end
    end else if (pop) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q      <= ST_HDR;
      line_id_q    <= '0;
      len_m1_q     <= '0;
      beat_cnt_q   <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      line_count_q <= '0;
      err_count_q  <= '0;
      err_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_id_q    <= line_id_d;
      len_m1_q     <= len_m1_d;
      beat_cnt_q   <= beat_cnt_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      line_count_q <= line_count_d;
      err_count_q  <= err_count_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

  assign bus.s_axis_h2c_tready  = s_ready && !user_rst;
  assign bus.m_axis_line_tdata  = out_q.data;
  assign bus.m_axis_line_tkeep  = out_q.keep;
  assign bus.m_axis_line_tlast  = out_q.last;
  assign bus.m_axis_line_tuser  = out_q.user;
  assign bus.m_axis_line_id     = out_q.id;
  assign bus.m_axis_line_tvalid = out_valid_q;
  assign line_count             = line_count_q;
  assign err_count              = err_count_q;
  assign err_pulse              = err_pulse_q;

endmodule
